// File: rtl/i2d_if_pf.sv
// i2d_if_pf: prefetching instruction-fetch unit for the i2d core.
// Issues sequential word fetches on the Wishbone instruction bus, queues
// {pc, instruction, error} entries in a small FIFO and hands them to decode
// in order. A redirect from execute flushes the queue and restarts fetch.

`ifndef I2D_INS_NOP
`define I2D_INS_NOP 6'h15
`endif

module i2d_if_pf #(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [DW-1:0] NOP_INS  = {`I2D_INS_NOP, 26'b0}
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] adr_o,
  output logic          stb_o,
  input  logic [DW-1:0] dat_i,
  input  logic          ack_i,
  input  logic          rty_i,
  input  logic          err_i,
  input  logic          if_dis,
  input  logic          set_pc,
  input  logic [AW-1:0] new_pc,
  output logic [DW-1:0] if_ins,
  output logic [AW-1:0] if_pc,
  output logic          if_valid,
  output logic          if_err,
  output logic          if_busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [AW-1:0]   fpc_r, fpc_s;
  logic [PW-1:0]   rd_ptr_r, wr_ptr_r;
  logic [CW-1:0]   count_r, count_s;
  logic [AW-1:0]   mem_pc_r  [DEPTH];
  logic [DW-1:0]   mem_ins_r [DEPTH];
  logic            mem_err_r [DEPTH];
  logic            full_s, empty_s, stb_s, push_s, pop_s;
  logic [AW-1:0]   tgt_pc_s;

  assign full_s   = (count_r == CW'(DEPTH));
  assign empty_s  = (count_r == {CW{1'b0}});
  // Word-align the redirect target; the low two bits are simply masked off.
  assign tgt_pc_s = new_pc & {{(AW-2){1'b1}}, 2'b00};

  // Bus request: only from registered state, dropped while reset is held.
  always_comb begin
    stb_s = 1'b0;
    case (state_r)
      ST_FETCH: stb_s = ~full_s & ~rst;
      ST_HALT:  stb_s = 1'b0;
      default:  stb_s = 1'b0;
    endcase
  end

  // A redirect cancels both the response push and the head pop of its cycle.
  assign push_s = stb_s & (err_i | ack_i) & ~set_pc;
  assign pop_s  = ~empty_s & ~if_dis & ~set_pc;

  // Fetch FSM next state and fetch-PC update; err wins over ack, rty holds.
  always_comb begin
    state_s = state_r;
    fpc_s   = fpc_r;
    if (stb_s && err_i) begin
      state_s = ST_HALT;
    end else if (stb_s && ack_i) begin
      fpc_s = fpc_r + AW'(3'd4);
    end else begin
      state_s = state_r;
      fpc_s   = fpc_r;
    end
  end

  // Occupancy update; simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CW'(1'b1);
      2'b01:   count_s = count_r - CW'(1'b1);
      default: count_s = count_r;
    endcase
  end

  // Control state: reset, then redirect/flush, then normal fetch/queue progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_FETCH;
      fpc_r    <= RESET_PC;
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (set_pc) begin
      state_r  <= ST_FETCH;
      fpc_r    <= tgt_pc_s;
      rd_ptr_r <= wr_ptr_r;
      count_r  <= {CW{1'b0}};
    end else begin
      state_r  <= state_s;
      fpc_r    <= fpc_s;
      count_r  <= count_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
    end
  end

  // FIFO storage: written at the tail on every accepted bus response.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_r[i]  <= {AW{1'b0}};
        mem_ins_r[i] <= {DW{1'b0}};
        mem_err_r[i] <= 1'b0;
      end
    end else if (push_s) begin
      mem_pc_r[wr_ptr_r]  <= fpc_r;
      mem_ins_r[wr_ptr_r] <= dat_i;
      mem_err_r[wr_ptr_r] <= err_i;
    end
  end

  // Decode-side view of the FIFO head; NOP/zero when nothing is queued.
  always_comb begin
    if (empty_s) begin
      if_ins = NOP_INS;
      if_pc  = {AW{1'b0}};
      if_err = 1'b0;
    end else begin
      if_ins = mem_ins_r[rd_ptr_r];
      if_pc  = mem_pc_r[rd_ptr_r];
      if_err = mem_err_r[rd_ptr_r];
    end
  end

  assign if_valid = ~empty_s;
  assign adr_o    = fpc_r;
  assign stb_o    = stb_s;
  assign if_busy  = stb_s & rty_i;

endmodule

// File: tb/tb_i2d_if_pf.sv
// Scoreboard bench for i2d_if_pf: directed bus responses, expected head
// entries queued at issue time and checked by an independent monitor.
module tb_i2d_if_pf;

  localparam logic [31:0] NOP = 32'h5400_0000;

  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr_o;
  logic        stb_o;
  logic [31:0] dat_i = 32'h0;
  logic        ack_i = 1'b0, rty_i = 1'b0, err_i = 1'b0;
  logic        if_dis = 1'b0, set_pc = 1'b0;
  logic [31:0] new_pc = 32'h0;
  logic [31:0] if_ins, if_pc;
  logic        if_valid, if_err, if_busy;

  ent_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  i2d_if_pf dut (
    .clk(clk), .rst(rst), .adr_o(adr_o), .stb_o(stb_o), .dat_i(dat_i),
    .ack_i(ack_i), .rty_i(rty_i), .err_i(err_i), .if_dis(if_dis),
    .set_pc(set_pc), .new_pc(new_pc), .if_ins(if_ins), .if_pc(if_pc),
    .if_valid(if_valid), .if_err(if_err), .if_busy(if_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset();
    chk("rst_stb", stb_o, 1'b0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_err", if_err, 1'b0);
    chk("rst_busy", if_busy, 1'b0);
    chk("rst_ins", if_ins, NOP);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_adr", adr_o, 32'h0);
  endtask

  // One bus cycle: drive inputs after the edge, check mid-cycle, queue expectation.
  // es/ev = -1 means that output is not checked this cycle.
  task automatic cyc(input logic a, input logic r, input logic e, input logic d,
                     input logic s, input logic [31:0] np,
                     input int es, input int ev, input logic [31:0] ea);
    @(posedge clk); #1;
    ack_i = a; rty_i = r; err_i = e; if_dis = d; set_pc = s; new_pc = np;
    dat_i = pat(ea);
    if (s) sb.delete();
    #2;
    chk("adr_o", adr_o, ea);
    if (es >= 0) begin
      chk("stb_o", stb_o, es[0]);
      chk("if_busy", if_busy, es[0] & r);
      if (es == 1 && !s && (a || e)) sb.push_back('{err: e, pc: ea, ins: pat(ea)});
    end
    if (ev >= 0) chk("if_valid", if_valid, ev[0]);
  endtask

  // Monitor: every consumed head entry must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && if_valid && !if_dis && !set_pc) begin
      chk("sb_level", (sb.size() == 0), 1'b0);
      if (sb.size() != 0) begin
        ent_t x;
        x = sb.pop_front();
        chk("head_pc", if_pc, x.pc);
        chk("head_ins", if_ins, x.ins);
        chk("head_err", if_err, x.err);
      end
    end
  end

  initial begin
    // Reset with a retry asserted: busy must stay low.
    rst = 1'b1; rty_i = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk_reset();
    @(posedge clk); #1;
    rst = 1'b0; rty_i = 1'b0;
    #2;
    chk("first_stb", stb_o, 1'b1);
    chk("first_adr", adr_o, 32'h0);
    chk("first_valid", if_valid, 1'b0);

    // Streaming with a zero-wait slave.
    cyc(1,0,0,0,0,0, 1,0, 32'd0);
    cyc(1,0,0,0,0,0, 1,1, 32'd4);
    cyc(1,0,0,0,0,0, 1,1, 32'd8);
    cyc(1,0,0,0,0,0, 1,1, 32'd12);
    cyc(0,0,0,0,0,0, 1,1, 32'd16);
    cyc(0,0,0,0,0,0, 1,0, 32'd16);

    // Decode stalled: fill to DEPTH, full blocks the request even with a pop.
    cyc(1,0,0,1,0,0, 1,0, 32'd16);
    cyc(1,0,0,1,0,0, 1,1, 32'd20);
    cyc(1,0,0,1,0,0, 1,1, 32'd24);
    cyc(1,0,0,1,0,0, 1,1, 32'd28);
    cyc(1,0,0,1,0,0, 0,1, 32'd32);
    cyc(1,0,0,0,0,0, 0,1, 32'd32);
    cyc(1,0,0,1,0,0, 1,1, 32'd32);
    cyc(0,0,0,1,0,0, 0,1, 32'd36);
    cyc(0,0,0,0,0,0, 0,1, 32'd36);
    cyc(0,0,0,0,0,0, 1,1, 32'd36);
    cyc(0,0,0,0,0,0, 1,1, 32'd36);
    cyc(0,0,0,0,0,0, 1,1, 32'd36);
    cyc(0,0,0,0,0,0, 1,0, 32'd36);

    // Retry three times at 0x20, then ack.
    cyc(0,0,0,0,1,32'h20, 1,0, 32'd36);
    for (int i = 0; i < 3; i++) cyc(0,1,0,0,0,0, 1,0, 32'h20);
    cyc(1,0,0,0,0,0, 1,0, 32'h20);
    cyc(0,0,0,0,0,0, 1,1, 32'h24);
    cyc(0,0,0,0,0,0, 1,0, 32'h24);

    // Redirect to 0x103 with three queued and an ack in the same cycle.
    cyc(1,0,0,1,0,0, 1,0, 32'h24);
    cyc(1,0,0,1,0,0, 1,1, 32'h28);
    cyc(1,0,0,1,0,0, 1,1, 32'h2C);
    cyc(1,0,0,0,1,32'h103, 1,1, 32'h30);
    cyc(1,0,0,0,0,0, 1,0, 32'h100);
    cyc(0,0,0,0,0,0, 1,1, 32'h104);
    cyc(0,0,0,0,0,0, 1,0, 32'h104);

    // Bus error at 0x40: halt until redirected.
    cyc(0,0,0,0,1,32'h40, 1,0, 32'h104);
    cyc(0,0,1,1,0,0, 1,0, 32'h40);
    for (int i = 0; i < 10; i++) cyc(1,0,0,1,0,0, 0,1, 32'h40);
    chk("halt_if_err", if_err, 1'b1);
    chk("halt_if_pc", if_pc, 32'h40);
    cyc(0,0,0,0,0,0, 0,1, 32'h40);
    cyc(0,0,0,0,0,0, 0,0, 32'h40);
    cyc(1,0,0,0,1,32'h80, 0,0, 32'h40);
    cyc(1,0,0,0,0,0, 1,0, 32'h80);
    cyc(0,0,0,0,0,0, 1,1, 32'h84);

    // Reset pulse with the FIFO half full and the request active.
    cyc(1,0,0,1,0,0, 1,0, 32'h84);
    cyc(1,0,0,1,0,0, 1,1, 32'h88);
    @(posedge clk); #1;
    rst = 1'b1; ack_i = 1'b1; dat_i = pat(32'h8C); sb.delete();
    #2;
    chk("rst_mid_stb", stb_o, 1'b0);
    @(posedge clk); #3;
    chk_reset();
    @(posedge clk); #1;
    rst = 1'b0; ack_i = 1'b0; if_dis = 1'b0;
    #2;
    chk("restart_stb", stb_o, 1'b1);
    chk("restart_adr", adr_o, 32'h0);
    cyc(1,0,0,0,0,0, 1,0, 32'd0);
    cyc(0,0,0,0,0,0, 1,1, 32'd4);
    cyc(0,0,0,0,0,0, 1,0, 32'd4);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2d_if_pf.md
# i2d_if_pf

Parametrised prefetching instruction-fetch unit for the i2d core. It replaces the single-register fetch stage. It issues sequential word fetches on the Wishbone instruction bus and queues {pc, instruction, error} entries in a DEPTH-entry FIFO. It delivers them in order to decode with a valid/stall handshake, and a taken branch from execute (`set_pc`) flushes the queue and redirects fetch.

## Interface
Parameters:
- `AW`, 32: address / PC width.
- `DW`, 32: instruction width.
- `DEPTH`, 4: prefetch FIFO entries; a power of two, ≥ 2.
- `RESET_PC`, 32'h0: fetch address after reset.
- `NOP_INS`, {`I2D_INS_NOP`, 26'b0}: instruction driven when no entry is valid.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `adr_o` out AW: bus address, always equal to the fetch PC.
- `stb_o` out 1: bus request (cyc and stb combined).
- `dat_i` in DW: read data.
- `ack_i` in 1: transfer complete, data valid.
- `rty_i` in 1: slave busy, retry the same address.
- `err_i` in 1: bus error.
- `if_dis` in 1: decode stall; the head entry is not consumed.
- `set_pc` in 1: redirect strobe.
- `new_pc` in AW: redirect target; bits [1:0] are ignored and forced to 0.
- `if_ins` out DW: head instruction, or NOP_INS when the FIFO is empty.
- `if_pc` out AW: PC of the head entry; 0 when the FIFO is empty.
- `if_valid` out 1: head entry present.
- `if_err` out 1: head entry is a faulting fetch (qualified by `if_valid`).
- `if_busy` out 1: retry seen this cycle (`stb_o & rty_i`).

## Operation
- Fetch FSM has two states: FETCH and HALT.
  - FETCH: `stb_o` = FIFO not full. A full FIFO blocks the request even if a pop occurs in the same cycle.
- Responses are sampled only while `stb_o` = 1, with priority err > ack > rty. Exactly one response is expected per cycle; no response means wait and hold `adr_o`.
- On ack: push {fpc, dat_i, 0}, then fpc ← fpc + 4. The increment wraps modulo 2^AW.
- On rty: no push, fpc held, `if_busy` = 1, and the request is reissued next cycle.
- On err: push {fpc, dat_i, 1} and go to HALT. In HALT, `stb_o` = 0 and fpc is held.
- Pop occurs when `if_valid & ~if_dis`. Push and pop may happen in the same cycle; the occupancy count is then unchanged.
- On `set_pc`, in any state:
  - The FIFO is flushed: read pointer = write pointer, count = 0.
  - fpc ← {new_pc[AW-1:2], 2'b00} and the state goes to FETCH.
  - A bus response in the same cycle is discarded: no push and no increment.
  - The pop of the head entry in that cycle is also discarded.
- `set_pc` has priority over every other event, including `rst` deassertion edge effects. Only `rst` overrides `set_pc`.
- The count is $clog2(DEPTH)+1 bits wide. Full = (count == DEPTH); empty = (count == 0). Pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- Reset values:
  - fpc = RESET_PC, state FETCH, FIFO empty.
  - `stb_o` = 0, `if_valid` = 0, `if_err` = 0, `if_busy` = 0.
  - `if_ins` = NOP_INS, `if_pc` = 0, `adr_o` = RESET_PC.
- The first `stb_o` is asserted in the first cycle after `rst` is deasserted.
- `rst` asserted mid-operation clears the FIFO and the FSM on the next edge. The bus request drops in that cycle and no partial entry survives.
- Latency: an ack in cycle N gives `if_valid` = 1 with that entry at the head in cycle N+1. Outputs are registered FIFO head reads; there is no dat_i-to-if_ins combinational path.
- Throughput: one instruction per cycle with a zero-wait slave while decode does not stall.
- `adr_o` and `stb_o` are functions of registered state only (fpc, state, count). They are stable for the whole cycle and never depend on `ack_i`, `rty_i`, or `err_i`.
- Redirect penalty: after `set_pc` in cycle N, the fetch of new_pc is issued in cycle N+1. The first new instruction is valid no earlier than N+2.
- In HALT, `if_err` stays visible at the head until it is popped or flushed. Fetch resumes only through `set_pc`.

## Test plan
- Reset release, slave acks every cycle, `if_dis` = 0:
  - Required: `adr_o` sequence 0, 4, 8, 12.
  - Required: `if_valid` first high one cycle after the first ack.
  - Required: `if_pc` 0, 4, 8 delivered one per cycle, with `if_ins` matching the data.
- `if_dis` held high with DEPTH = 4:
  - Required: exactly four pushes, then `stb_o` = 0 with `adr_o` = 16.
  - Required: releasing `if_dis` for one cycle pops pc 0, and `stb_o` reasserts the following cycle.
- `rty_i` for 3 cycles at 0x20, then ack:
  - Required: `if_busy` = 1 for those 3 cycles and `adr_o` holds 0x20.
  - Required: a single entry with pc 0x20 is queued.
- `set_pc` with new_pc = 0x103 while 3 entries are queued and an ack arrives in the same cycle:
  - Required: the FIFO is empty the next cycle and the acked data is dropped.
  - Required: `adr_o` = 0x100, and the next valid `if_pc` = 0x100.
- `err_i` at 0x40:
  - Required: an entry with pc 0x40 and `if_err` = 1 reaches the head, and `stb_o` stays 0 for 10 cycles.
  - Required: `set_pc` to 0x80 resumes fetch at 0x80.
- `rst` pulsed while the FIFO is half full and `stb_o` is high:
  - Required: all outputs return to their reset values next cycle.
  - Required: fetch restarts at RESET_PC.
